// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared definitions for the memory-access stage: access-size
//                encodings, FSM state type, byte-mask constants and helpers
//                that map an access size onto strobe / alignment masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // Access size encodings (instruction funct3[1:0])
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Byte-lane masks for an access starting at lane 0
    localparam logic [7:0] BYTE_MASK_B = 8'h01;
    localparam logic [7:0] BYTE_MASK_H = 8'h03;
    localparam logic [7:0] BYTE_MASK_W = 8'h0F;
    localparam logic [7:0] BYTE_MASK_D = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Strobe pattern for an access of the given size at lane 0
    function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = BYTE_MASK_B;
            SZ_H:    m = BYTE_MASK_H;
            SZ_W:    m = BYTE_MASK_W;
            default: m = BYTE_MASK_D;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_low_mask(input logic [1:0] sz);
        logic [2:0] m;
        case (sz)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align_extend.sv
`default_nettype none
// ============================================================================
//  Module      : load_align_extend
//  Description : Combinational load formatter. Moves the addressed bytes of a
//                64-bit memory word down to bit 0 and sign- or zero-extends
//                them according to the access size.
//  Ports       : rdata       in  XLEN  raw memory read word
//                off         in  3     byte offset within the word
//                size        in  2     access size (B/H/W/D)
//                is_unsigned in  1     zero-extend instead of sign-extend
//                value       out XLEN  formatted load result
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align_extend
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = rdata >> {off, 3'b000};

    always_comb begin
        value = w_shifted;
        case (size)
            SZ_B: value = is_unsigned ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                      : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            SZ_H: value = is_unsigned ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                      : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            SZ_W: value = is_unsigned ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                      : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            default: value = w_shifted;  // doubleword: no extension
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : RISC-V memory stage. Non-memory instructions pass through to
//                write-back in one cycle; loads/stores issue a registered
//                req/ack data-memory transaction and stall upstream until the
//                acknowledge arrives.
//  Config      : MISALIGN_TRAP_EN - when defined, misaligned memory ops raise
//                misalign_trap instead of accessing memory; when undefined
//                the offset is aligned down to the access size.
//  Ports       : clk, reset (sync, active-high)
//                in_valid/in_ready, alu_result, rs2_data, rd_addr, reg_write,
//                mem_read, mem_write, size, is_unsigned  - upstream side
//                dmem_req/we/addr/wdata/wstrb, dmem_rdata/ack - memory side
//                wb_valid/data/rd/reg_write, misalign_trap     - write-back
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [REGW-1:0] rd_addr,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_data,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_reg_write,
    output logic            misalign_trap
);

    state_t r_state, w_state_next;

    // Fields captured at accept and needed when the ack returns
    logic [2:0]      r_off, w_off_next;
    logic [1:0]      r_size, w_size_next;
    logic            r_unsigned, w_unsigned_next;
    logic            r_is_store, w_is_store_next;
    logic            r_reg_write, w_reg_write_next;
    logic [REGW-1:0] r_rd, w_rd_next;

    // Next values of the registered outputs
    logic            w_req_next, w_we_next, w_wb_valid_next, w_wb_rw_next;
    logic [XLEN-1:0] w_addr_next, w_wdata_next, w_wb_data_next;
    logic [7:0]      w_wstrb_next;
    logic [REGW-1:0] w_wb_rd_next;

    logic            w_is_mem;
    logic            w_trap_hit;
    logic [2:0]      w_off_eff;
    logic [2:0]      w_low_mask;
    logic [XLEN-1:0] w_load_value;

    assign in_ready   = (r_state == IDLE);
    assign w_is_mem   = mem_read | mem_write;
    assign w_low_mask = size_low_mask(size);

`ifdef MISALIGN_TRAP_EN
    logic w_misaligned;
    logic w_trap_next;
    logic r_trap;

    assign w_misaligned  = (alu_result[2:0] & w_low_mask) != 3'b000;
    assign w_trap_hit    = w_misaligned;
    assign w_off_eff     = alu_result[2:0];
    assign w_trap_next   = in_valid && (r_state == IDLE) && w_is_mem && w_misaligned;
    assign misalign_trap = r_trap;

    always_ff @(posedge clk) begin
        if (reset) r_trap <= 1'b0;
        else       r_trap <= w_trap_next;
    end
`else
    // Misaligned accesses are silently pulled down to the size boundary
    assign w_trap_hit    = 1'b0;
    assign w_off_eff     = alu_result[2:0] & ~w_low_mask;
    assign misalign_trap = 1'b0;
`endif

    load_align_extend #(
        .XLEN        (XLEN)
    ) u_load_align_extend (
        .rdata       (dmem_rdata),
        .off         (r_off),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .value       (w_load_value)
    );

    always_comb begin
        w_state_next     = r_state;
        w_off_next       = r_off;
        w_size_next      = r_size;
        w_unsigned_next  = r_unsigned;
        w_is_store_next  = r_is_store;
        w_reg_write_next = r_reg_write;
        w_rd_next        = r_rd;
        w_req_next       = dmem_req;
        w_we_next        = dmem_we;
        w_addr_next      = dmem_addr;
        w_wdata_next     = dmem_wdata;
        w_wstrb_next     = dmem_wstrb;
        w_wb_valid_next  = 1'b0;
        w_wb_data_next   = wb_data;
        w_wb_rd_next     = wb_rd;
        w_wb_rw_next     = wb_reg_write;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (!w_is_mem) begin
                        w_wb_valid_next = 1'b1;
                        w_wb_data_next  = alu_result;
                        w_wb_rd_next    = rd_addr;
                        w_wb_rw_next    = reg_write;
                    end else if (w_trap_hit) begin
                        // Faulting access: report the bad address, no rd update
                        w_wb_valid_next = 1'b1;
                        w_wb_data_next  = alu_result;
                        w_wb_rd_next    = rd_addr;
                        w_wb_rw_next    = 1'b0;
                    end else begin
                        w_state_next     = BUSY;
                        w_req_next       = 1'b1;
                        w_we_next        = mem_write;
                        w_addr_next      = {alu_result[XLEN-1:3], 3'b000};
                        w_wdata_next     = rs2_data << {w_off_eff, 3'b000};
                        w_wstrb_next     = size_byte_mask(size) << w_off_eff;
                        w_off_next       = w_off_eff;
                        w_size_next      = size;
                        w_unsigned_next  = is_unsigned;
                        w_is_store_next  = mem_write;
                        // A store never writes rd, even if mem_read was also set
                        w_reg_write_next = mem_write ? 1'b0 : reg_write;
                        w_rd_next        = rd_addr;
                    end
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    w_state_next    = IDLE;
                    w_req_next      = 1'b0;
                    w_we_next       = 1'b0;
                    w_wb_valid_next = 1'b1;
                    w_wb_rd_next    = r_rd;
                    if (r_is_store) begin
                        w_wb_rw_next = 1'b0;
                    end else begin
                        w_wb_rw_next   = r_reg_write;
                        w_wb_data_next = w_load_value;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_off        <= 3'b000;
            r_size       <= SZ_B;
            r_unsigned   <= 1'b0;
            r_is_store   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= 8'h00;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_off        <= w_off_next;
            r_size       <= w_size_next;
            r_unsigned   <= w_unsigned_next;
            r_is_store   <= w_is_store_next;
            r_reg_write  <= w_reg_write_next;
            r_rd         <= w_rd_next;
            dmem_req     <= w_req_next;
            dmem_we      <= w_we_next;
            dmem_addr    <= w_addr_next;
            dmem_wdata   <= w_wdata_next;
            dmem_wstrb   <= w_wstrb_next;
            wb_valid     <= w_wb_valid_next;
            wb_data      <= w_wb_data_next;
            wb_rd        <= w_wb_rd_next;
            wb_reg_write <= w_wb_rw_next;
        end
    end

endmodule
`default_nettype wire
